player_match_ctrl: RTL and testbench
====================================

PLAYER_MATCH_CTRL -- requirements
Module: player_match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 15: points needed to win a match (range 1..30).
REQ-002 Parameter SERVE_CYCLES, default 50_000_000: clk cycles held in SERVE.
REQ-003 Parameter POINT_CYCLES, default 100_000_000: clk cycles held in POINT after a landing.
REQ-004 Parameter NET_X, default 160: x coordinate dividing left court (x < NET_X) from right court.
REQ-005 clk  input  1  single system clock; all logic on posedge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 start_btn  input  1  debounced start-button level.
REQ-008 ball_ground  input  1  one-cycle pulse: ball touched the floor.
REQ-009 ball_x  input  12  ball centre x at the landing, in 320-wide buffer coordinates.
REQ-010 game_state  output  2  0 = IDLE, 1 = SERVE (players and ball return to start positions), 2 = PLAY, 3 = OVER.
REQ-011 score_l, score_r  output  5 each  point counters for the left and right players.
REQ-012 serve_side  output  1  0 = left serves, 1 = right serves.
REQ-013 winner  output  1  side that won; valid only while game_state == 3.

Function
REQ-014 Internal FSM states: IDLE, SERVE, PLAY, POINT, OVER; game_state mapping: IDLE->0, SERVE->1, PLAY->2, POINT->2, OVER->3; output registered, no combinational path from inputs.
REQ-015 Start press = start_btn high while its previous-cycle sample was low; held level counts as a single press.
REQ-016 IDLE: start press -> SERVE next cycle; score_l and score_r cleared to 0 on that same edge.
REQ-017 SERVE: 32-bit timer counts from 0; on the cycle the timer equals SERVE_CYCLES-1 -> PLAY, timer cleared; ball_ground ignored.
REQ-018 PLAY: ball_ground pulse -> POINT next cycle; ball_x < NET_X -> score_r +1 and serve_side <= 1; otherwise score_l +1 and serve_side <= 0.
REQ-019 Score increments saturate at 31; both counters never change on the same edge.
REQ-020 POINT: timer counts to POINT_CYCLES-1, then -> OVER if the win condition holds, else -> SERVE; ball_ground ignored.
REQ-021 Win condition, macro absent: a score has reached WIN_SCORE; winner <= 0 if score_l is the winning score, else 1.
REQ-022 OVER: scores and winner held; start press -> SERVE with both scores cleared and serve_side <= 0.
REQ-023 A start press in SERVE, PLAY or POINT is ignored.
REQ-024 A ball_ground pulse coinciding with the PLAY entry edge is accepted only from the following cycle.

Reset
REQ-025 reset_n low at a clk edge: state IDLE, game_state 0, score_l 0, score_r 0, serve_side 0, winner 0, timer 0, edge-detect register 0.
REQ-026 Reset mid-operation (any state, any timer value) takes priority over every transition; the first cycle after release behaves as IDLE.

Configuration
REQ-027 Macro MATCH_WIN_BY_TWO_EN compiled in: the win condition additionally requires a lead of at least 2 points.
REQ-028 Under MATCH_WIN_BY_TWO_EN, a score reaching 31 wins regardless of lead.
REQ-029 Without MATCH_WIN_BY_TWO_EN: first to WIN_SCORE wins; no lead-comparison logic is synthesised.

Verification (SERVE_CYCLES=4, POINT_CYCLES=8, WIN_SCORE=3)
REQ-030 Reset, then start press -> game_state 1 for exactly 4 cycles, then 2; scores 0/0.
REQ-031 In PLAY, ball_ground with ball_x=100 -> next cycle score_r=1, serve_side=1, game_state held at 2 for 8 cycles, then 1.
REQ-032 Three left-court landings (ball_x=50) without macro -> after the last POINT, game_state=3, winner=1, score_r=3; a later start press -> game_state 1, scores 0/0.
REQ-033 With MATCH_WIN_BY_TWO_EN: at 2-2, right scores -> 2-3, back to SERVE; right scores again -> 2-4, OVER, winner=1.
REQ-034 start_btn held high through the full match and ball_ground pulsed during SERVE/POINT -> no extra state changes, no score changes.
REQ-035 reset_n low for 1 cycle in mid-POINT with score 2-1 -> next cycle game_state 0, scores 0/0, serve_side 0.

Source files
------------

// File: rtl/player_match_ctrl.sv
// rtl/player_match_ctrl.sv - two-player match sequencer: serve/play/point timing, scoring, win detection
// Optional macro MATCH_WIN_BY_TWO_EN: win additionally needs a 2-point lead (31 always wins).
module player_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 15,
  parameter int unsigned SERVE_CYCLES = 50_000_000,
  parameter int unsigned POINT_CYCLES = 100_000_000,
  parameter int unsigned NET_X        = 160
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_btn,
  input  logic        ball_ground,
  input  logic [11:0] ball_x,
  output logic [1:0]  game_state,
  output logic [4:0]  score_l,
  output logic [4:0]  score_r,
  output logic        serve_side,
  output logic        winner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_POINT,
    S_OVER
  } state_t;

  localparam logic [31:0] SERVE_LAST = 32'(SERVE_CYCLES - 1);
  localparam logic [31:0] POINT_LAST = 32'(POINT_CYCLES - 1);
  localparam logic [11:0] NET_POS    = 12'(NET_X);
  localparam logic [4:0]  WIN_PTS    = 5'(WIN_SCORE);
  localparam logic [4:0]  SCORE_MAX  = 5'd31;

  state_t      state, state_next;
  logic [31:0] timer, timer_next;
  logic        start_prev;
  logic        start_press;
  logic [4:0]  score_l_next, score_r_next;
  logic        serve_side_next, winner_next;
  logic [1:0]  game_state_next;
  logic        win_l, win_r;

  assign start_press = start_btn & ~start_prev;

`ifdef MATCH_WIN_BY_TWO_EN
  assign win_l = (score_l == SCORE_MAX) ||
                 ((score_l >= WIN_PTS) && ({1'b0, score_l} >= {1'b0, score_r} + 6'd2));
  assign win_r = (score_r == SCORE_MAX) ||
                 ((score_r >= WIN_PTS) && ({1'b0, score_r} >= {1'b0, score_l} + 6'd2));
`else
  assign win_l = (score_l >= WIN_PTS);
  assign win_r = (score_r >= WIN_PTS);
`endif

  always_comb begin
    state_next      = state;
    timer_next      = timer;
    score_l_next    = score_l;
    score_r_next    = score_r;
    serve_side_next = serve_side;
    winner_next     = winner;
    case (state)
      S_IDLE: begin
        if (start_press) begin
          state_next   = S_SERVE;
          timer_next   = 32'd0;
          score_l_next = 5'd0;
          score_r_next = 5'd0;
        end
      end
      S_SERVE: begin
        if (timer == SERVE_LAST) begin
          state_next = S_PLAY;
          timer_next = 32'd0;
        end else begin
          timer_next = timer + 32'd1;
        end
      end
      S_PLAY: begin
        if (ball_ground) begin
          state_next = S_POINT;
          timer_next = 32'd0;
          // A landing in the left court is a point for the right player.
          if (ball_x < NET_POS) begin
            score_r_next    = (score_r == SCORE_MAX) ? score_r : score_r + 5'd1;
            serve_side_next = 1'b1;
          end else begin
            score_l_next    = (score_l == SCORE_MAX) ? score_l : score_l + 5'd1;
            serve_side_next = 1'b0;
          end
        end
      end
      S_POINT: begin
        if (timer == POINT_LAST) begin
          timer_next = 32'd0;
          if (win_l || win_r) begin
            state_next  = S_OVER;
            winner_next = win_l ? 1'b0 : 1'b1;
          end else begin
            state_next = S_SERVE;
          end
        end else begin
          timer_next = timer + 32'd1;
        end
      end
      S_OVER: begin
        if (start_press) begin
          state_next      = S_SERVE;
          timer_next      = 32'd0;
          score_l_next    = 5'd0;
          score_r_next    = 5'd0;
          serve_side_next = 1'b0;
        end
      end
      default: begin
        state_next = S_IDLE;
        timer_next = 32'd0;
      end
    endcase

    case (state_next)
      S_SERVE:         game_state_next = 2'd1;
      S_PLAY, S_POINT: game_state_next = 2'd2;
      S_OVER:          game_state_next = 2'd3;
      default:         game_state_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      timer      <= 32'd0;
      start_prev <= 1'b0;
      score_l    <= 5'd0;
      score_r    <= 5'd0;
      serve_side <= 1'b0;
      winner     <= 1'b0;
      game_state <= 2'd0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      start_prev <= start_btn;
      score_l    <= score_l_next;
      score_r    <= score_r_next;
      serve_side <= serve_side_next;
      winner     <= winner_next;
      game_state <= game_state_next;
    end
  end

endmodule

// File: tb/tb_player_match_ctrl.sv
// tb/tb_player_match_ctrl.sv - directed and randomized match sequences against a score/timeline model
module tb_player_match_ctrl;

  localparam int SC = 4;
  localparam int PC = 8;
  localparam int WS = 3;
  localparam int NX = 160;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_btn = 1'b0;
  logic        ball_ground = 1'b0;
  logic [11:0] ball_x = 12'd0;
  logic [1:0]  game_state;
  logic [4:0]  score_l, score_r;
  logic        serve_side, winner;

  int vectors = 0;
  int errors  = 0;
  int m_l = 0, m_r = 0, m_ss = 0, m_win = 0;
  bit hold = 1'b0;
  bit in_over = 1'b0;
  bit over;

  player_match_ctrl #(
    .WIN_SCORE(WS), .SERVE_CYCLES(SC), .POINT_CYCLES(PC), .NET_X(NX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn), .ball_ground(ball_ground),
    .ball_x(ball_x), .game_state(game_state), .score_l(score_l), .score_r(score_r),
    .serve_side(serve_side), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit won_l();
`ifdef MATCH_WIN_BY_TWO_EN
    return (m_l == 31) || (m_l >= WS && m_l - m_r >= 2);
`else
    return m_l >= WS;
`endif
  endfunction

  function automatic bit won_r();
`ifdef MATCH_WIN_BY_TWO_EN
    return (m_r == 31) || (m_r >= WS && m_r - m_l >= 2);
`else
    return m_r >= WS;
`endif
  endfunction

  // Start button activity that must never be seen as a press mid-match.
  task automatic noise();
    start_btn = hold ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic check_scores(input string tag);
    check({tag, "_score_l"}, score_l, m_l);
    check({tag, "_score_r"}, score_r, m_r);
  endtask

  task automatic press();
    start_btn = 1'b0;
    step();
    check("pre_press_gs", game_state, in_over ? 3 : 0);
    if (in_over) check("over_winner_held", winner, m_win);
    start_btn = 1'b1;
    step();
    start_btn = hold;
    m_l = 0;
    m_r = 0;
    if (in_over) m_ss = 0;
    in_over = 1'b0;
    check("press_gs", game_state, 1);
    check_scores("press");
    check("press_serve_side", serve_side, m_ss);
  endtask

  // One rally from the first SERVE cycle; cut > 0 stops after that many POINT cycles.
  task automatic rally(input int x, input int cut, output bit is_over);
    is_over = 1'b0;
    for (int i = 0; i < SC; i++) begin
      check("serve_gs", game_state, 1);
      noise();
      ball_ground = (i == SC - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
      ball_ground = 1'b0;
    end
    check("play_entry_gs", game_state, 2);
    check_scores("serve");
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      noise();
      step();
      check("play_wait_gs", game_state, 2);
    end
    ball_x = 12'(x);
    ball_ground = 1'b1;
    noise();
    step();
    ball_ground = 1'b0;
    if (x < NX) begin
      if (m_r < 31) m_r++;
      m_ss = 1;
    end else begin
      if (m_l < 31) m_l++;
      m_ss = 0;
    end
    check("land_gs", game_state, 2);
    check_scores("land");
    check("land_serve_side", serve_side, m_ss);
    for (int i = 1; i < PC; i++) begin
      if (cut > 0 && i > cut) return;
      noise();
      ball_ground = 1'($urandom_range(0, 1));
      step();
      ball_ground = 1'b0;
      check("point_gs", game_state, 2);
    end
    noise();
    ball_ground = 1'($urandom_range(0, 1));
    step();
    ball_ground = 1'b0;
    is_over = won_l() || won_r();
    check_scores("point_end");
    if (is_over) begin
      m_win = won_l() ? 0 : 1;
      in_over = 1'b1;
      check("over_gs", game_state, 3);
      check("over_winner", winner, m_win);
    end else begin
      check("next_serve_gs", game_state, 1);
    end
  endtask

  task automatic play_match(input bit hold_mode);
    int n;
    hold = hold_mode;
    press();
    n = 0;
    do begin
      rally(int'($urandom_range(0, 319)), 0, over);
      n++;
    end while (!over && n < 80);
    check("match_bound", over, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    step();
    step();
    check("rst_gs", game_state, 0);
    check("rst_score_l", score_l, 0);
    check("rst_score_r", score_r, 0);
    check("rst_serve_side", serve_side, 0);
    check("rst_winner", winner, 0);
    reset_n = 1'b1;
    step();
    check("idle_hold_gs", game_state, 0);

    press();
    rally(100, 0, over);
    rally(50, 0, over);
    rally(50, 0, over);
    check("left_landings_over", over, 1);
    check("left_landings_score_r", score_r, 3);
    check("left_landings_winner", winner, 1);

`ifdef MATCH_WIN_BY_TWO_EN
    press();
    rally(200, 0, over);
    rally(200, 0, over);
    rally(50, 0, over);
    rally(50, 0, over);
    rally(50, 0, over);
    check("two_three_not_over", over, 0);
    rally(50, 0, over);
    check("two_four_over", over, 1);
    check("two_four_winner", winner, 1);
`endif

    press();
    rally(200, 0, over);
    rally(200, 0, over);
    rally(50, 3, over);
    check("mid_point_score_l", score_l, 2);
    check("mid_point_score_r", score_r, 1);
    start_btn = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    m_l = 0;
    m_r = 0;
    m_ss = 0;
    in_over = 1'b0;
    check("mid_rst_gs", game_state, 0);
    check_scores("mid_rst");
    check("mid_rst_serve_side", serve_side, 0);
    step();
    check("post_rst_idle_gs", game_state, 0);

    play_match(1'b0);
    play_match(1'b1);
    play_match(1'b0);
    play_match(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
